audio_sample_buffer: RTL and testbench

Upstream feeder for the HDMI audio sample packet stage. Accepts stereo L-PCM samples on the pixel clock, buffers them in a small FIFO, and on request from the data-island scheduler presents up to 4 stereo samples per packet. It also supplies the matching sample-present mask and the IEC 60958 channel-status frame counter (0..191) that the packet stage consumes.

---
 rtl/audio_sample_buffer.sv | 234 +++++++++++++++++++++++
 tb/tb_audio_sample_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_buffer.sv
// audio_sample_buffer: stereo L-PCM sample FIFO feeding the HDMI audio sample
// packet stage. Samples arrive on clk_pixel, are MSB-aligned into 24-bit words
// and buffered. On packet_load the oldest (up to MAX_SAMPLES) entries are
// latched into the packet word registers with a contiguous present mask. They
// are held until packet_done, which pops them and advances the IEC 60958
// channel-status frame counter (0..191, wrapping).
//
// Optional build macro: AUDIO_BUF_STATS_EN
//   When defined, adds a saturating 16-bit overflow_count output and an
//   underrun pulse (packet_load seen in IDLE while the FIFO is empty).
//   When undefined, neither port exists and behaviour is otherwise identical.

module audio_sample_buffer #(
    parameter int DEPTH       = 16,
    parameter int MAX_SAMPLES = 4,
    parameter int BIT_WIDTH   = 24
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic [BIT_WIDTH-1:0]         sample_left,
    input  logic [BIT_WIDTH-1:0]         sample_right,
    input  logic                         packet_load,
    input  logic                         packet_done,
    output logic                         packet_valid,
    output logic [7:0]                   frame_counter,
    output logic [3:0][1:0][23:0]        audio_sample_word,
    output logic [3:0]                   audio_sample_word_present,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic                         overflow
`ifdef AUDIO_BUF_STATS_EN
    ,
    output logic [15:0]                  overflow_count,
    output logic                         underrun
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = AW + 1;
    localparam int SHIFT = 24 - BIT_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Storage: one entry holds {left[23:0], right[23:0]} already MSB-aligned.
    logic [47:0]            fifo_mem [DEPTH];

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]          fill_q, fill_d;
    state_t                 state_q, state_d;
    logic [2:0]             held_n_q, held_n_d;
    logic                   packet_valid_q, packet_valid_d;
    logic [7:0]             frame_counter_q, frame_counter_d;
    logic [3:0]             present_q, present_d;
    logic [3:0][1:0][23:0]  word_q, word_d;
    logic                   overflow_q, overflow_d;

    logic                   fifo_full;
    logic                   push;
    logic                   drop;
    logic                   underrun_evt;
    logic [2:0]             n_avail;
    logic [2:0]             pop_count;
    logic [8:0]             fc_sum;
    logic [23:0]            left_aligned;
    logic [23:0]            right_aligned;

    logic [AW-1:0]          slot_idx   [4];
    logic [47:0]            slot_entry [4];

    // Narrow samples are left-justified; the unused low bits become zero.
    assign left_aligned  = 24'(sample_left)  << SHIFT;
    assign right_aligned = 24'(sample_right) << SHIFT;

    // Fullness is judged on the pre-update occupancy, so a pop in the same
    // cycle never makes room for an incoming sample.
    assign fifo_full    = (fill_q == FW'(DEPTH));
    assign push         = sample_valid && !fifo_full;
    assign drop         = sample_valid && fifo_full;
    assign underrun_evt = (state_q == ST_IDLE) && packet_load && (fill_q == '0);

    // Peek addresses for the four oldest entries (pointer arithmetic wraps).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_idx[gi]   = rd_ptr_q + AW'(gi);
            assign slot_entry[gi] = fifo_mem[slot_idx[gi]];
        end
    endgenerate

    // Number of samples a packet takes now: min(fill_level, MAX_SAMPLES).
    always_comb begin
        n_avail = 3'(MAX_SAMPLES);
        if (fill_q < FW'(MAX_SAMPLES)) begin
            n_avail = 3'(fill_q);
        end
    end

    // Sample storage write port; pointers make stale contents unreachable.
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {left_aligned, right_aligned};
        end
    end

    // Next-state logic for the packet FSM, FIFO pointers and output registers.
    always_comb begin
        state_d         = state_q;
        held_n_d        = held_n_q;
        packet_valid_d  = packet_valid_q;
        frame_counter_d = frame_counter_q;
        present_d       = present_q;
        word_d          = word_q;
        pop_count       = 3'd0;
        fc_sum          = 9'd0;
        overflow_d      = drop;

        case (state_q)
            ST_IDLE: begin
                // packet_done here is meaningless and ignored.
                if (packet_load && (fill_q != '0)) begin
                    state_d        = ST_HOLD;
                    packet_valid_d = 1'b1;
                    held_n_d       = n_avail;
                    for (int i = 0; i < 4; i++) begin
                        if (3'(i) < n_avail) begin
                            present_d[i]  = 1'b1;
                            word_d[i][0] = slot_entry[i][47:24];
                            word_d[i][1] = slot_entry[i][23:0];
                        end else begin
                            present_d[i] = 1'b0;
                            word_d[i]    = '0;
                        end
                    end
                end
            end
            ST_HOLD: begin
                // Held contents stay frozen; a coincident packet_load is dropped
                // so the scheduler must issue a fresh load after release.
                if (packet_done) begin
                    pop_count = held_n_q;
                    fc_sum    = {1'b0, frame_counter_q} + 9'(held_n_q);
                    if (fc_sum >= 9'd192) begin
                        fc_sum = fc_sum - 9'd192;
                    end
                    frame_counter_d = fc_sum[7:0];
                    present_d       = 4'b0000;
                    word_d          = '0;
                    packet_valid_d  = 1'b0;
                    held_n_d        = 3'd0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer and occupancy updates; held entries remain counted until popped.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop_count);
        fill_d   = fill_q + FW'(push) - FW'(pop_count);
    end

    // State registers with synchronous reset discarding everything buffered.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fill_q          <= '0;
            held_n_q        <= 3'd0;
            packet_valid_q  <= 1'b0;
            frame_counter_q <= 8'd0;
            present_q       <= 4'b0000;
            word_q          <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fill_q          <= fill_d;
            held_n_q        <= held_n_d;
            packet_valid_q  <= packet_valid_d;
            frame_counter_q <= frame_counter_d;
            present_q       <= present_d;
            word_q          <= word_d;
            overflow_q      <= overflow_d;
        end
    end

    assign packet_valid              = packet_valid_q;
    assign frame_counter             = frame_counter_q;
    assign audio_sample_word         = word_q;
    assign audio_sample_word_present = present_q;
    assign fill_level                = fill_q;
    assign overflow                  = overflow_q;

`ifdef AUDIO_BUF_STATS_EN
    logic [15:0] overflow_count_q, overflow_count_d;
    logic        underrun_q, underrun_d;

    // Saturating drop counter and empty-load indicator.
    always_comb begin
        overflow_count_d = overflow_count_q;
        if (drop && (overflow_count_q != 16'hFFFF)) begin
            overflow_count_d = overflow_count_q + 16'd1;
        end
        underrun_d = underrun_evt;
    end

    // Statistics registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            overflow_count_q <= 16'd0;
            underrun_q       <= 1'b0;
        end else begin
            overflow_count_q <= overflow_count_d;
            underrun_q       <= underrun_d;
        end
    end

    assign overflow_count = overflow_count_q;
    assign underrun       = underrun_q;
`else
    logic unused_stats;
    assign unused_stats = underrun_evt;
`endif

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer: a table of one-cycle vectors with
// hand-computed expectations, then hand-written multi-cycle sequences for
// overflow, frame-counter wrap, load/done collision and reset during HOLD.

module tb_audio_sample_buffer;

    localparam int DEPTH = 16;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic                  clk_pixel;
    logic                  reset;
    logic                  sample_valid;
    logic [23:0]           sample_left;
    logic [23:0]           sample_right;
    logic                  packet_load;
    logic                  packet_done;
    logic                  packet_valid;
    logic [7:0]            frame_counter;
    logic [3:0][1:0][23:0] audio_sample_word;
    logic [3:0]            audio_sample_word_present;
    logic [FW-1:0]         fill_level;
    logic                  overflow;
`ifdef AUDIO_BUF_STATS_EN
    logic [15:0]           overflow_count;
    logic                  underrun;
`endif

    audio_sample_buffer #(
        .DEPTH(DEPTH),
        .MAX_SAMPLES(4),
        .BIT_WIDTH(24)
    ) dut (
        .clk_pixel                 (clk_pixel),
        .reset                     (reset),
        .sample_valid              (sample_valid),
        .sample_left               (sample_left),
        .sample_right              (sample_right),
        .packet_load               (packet_load),
        .packet_done               (packet_done),
        .packet_valid              (packet_valid),
        .frame_counter             (frame_counter),
        .audio_sample_word         (audio_sample_word),
        .audio_sample_word_present (audio_sample_word_present),
        .fill_level                (fill_level),
        .overflow                  (overflow)
`ifdef AUDIO_BUF_STATS_EN
        ,
        .overflow_count            (overflow_count),
        .underrun                  (underrun)
`endif
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic        rst;
        logic        sv;
        logic [23:0] l;
        logic [23:0] r;
        logic        ld;
        logic        dn;
        logic        pv;
        logic [3:0]  pr;
        logic [7:0]  fc;
        logic [7:0]  fill;
        logic        ovf;
        int          widx;
        logic [23:0] wl;
        logic [23:0] wr;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_miss    = 0;

    task automatic add_vec(input logic rst, input logic sv, input logic [23:0] l,
                           input logic [23:0] r, input logic ld, input logic dn,
                           input logic pv, input logic [3:0] pr, input logic [7:0] fc,
                           input logic [7:0] fill, input logic ovf, input int widx,
                           input logic [23:0] wl, input logic [23:0] wr);
        vec_t v;
        v.rst = rst; v.sv = sv; v.l = l; v.r = r; v.ld = ld; v.dn = dn;
        v.pv = pv; v.pr = pr; v.fc = fc; v.fill = fill; v.ovf = ovf;
        v.widx = widx; v.wl = wl; v.wr = wr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply(input logic rst, input logic sv, input logic [23:0] l,
                         input logic [23:0] r, input logic ld, input logic dn);
        reset        = rst;
        sample_valid = sv;
        sample_left  = l;
        sample_right = r;
        packet_load  = ld;
        packet_done  = dn;
        @(posedge clk_pixel);
        #1;
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_left  = 24'd0;
        sample_right = 24'd0;
        packet_load  = 1'b0;
        packet_done  = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic pv, input logic [3:0] pr,
                             input logic [7:0] fc, input logic [7:0] fill);
        chk({tag, " packet_valid"}, 32'(packet_valid), 32'(pv));
        chk({tag, " present"}, 32'(audio_sample_word_present), 32'(pr));
        chk({tag, " frame_counter"}, 32'(frame_counter), 32'(fc));
        chk({tag, " fill_level"}, 32'(fill_level), 32'(fill));
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [23:0] l,
                            input logic [23:0] r);
        chk($sformatf("%s word[%0d][0]", tag, idx), 32'(audio_sample_word[idx][0]), 32'(l));
        chk($sformatf("%s word[%0d][1]", tag, idx), 32'(audio_sample_word[idx][1]), 32'(r));
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_left  = 24'd0;
        sample_right = 24'd0;
        packet_load  = 1'b0;
        packet_done  = 1'b0;
        repeat (2) @(posedge clk_pixel);
        #1;

        // ---------------- table-driven vectors ----------------
        //       rst sv  l          r          ld dn  pv pr       fc  fill ovf w  wl         wr
        add_vec(1, 0, 24'h0,      24'h0,      0, 0,  0, 4'b0000, 0,  0,  0,  0, 24'h0,      24'h0);
        add_vec(0, 1, 24'h000001, 24'h100001, 0, 0,  0, 4'b0000, 0,  1,  0,  0, 24'h0,      24'h0);
        add_vec(0, 1, 24'h000002, 24'h100002, 0, 0,  0, 4'b0000, 0,  2,  0,  0, 24'h0,      24'h0);
        add_vec(0, 1, 24'h000003, 24'h100003, 0, 0,  0, 4'b0000, 0,  3,  0,  0, 24'h0,      24'h0);
        add_vec(0, 0, 24'h0,      24'h0,      1, 0,  1, 4'b0111, 0,  3,  0,  2, 24'h000003, 24'h100003);
        add_vec(0, 0, 24'h0,      24'h0,      0, 0,  1, 4'b0111, 0,  3,  0,  3, 24'h0,      24'h0);
        // load ignored in HOLD; sample written while held queues behind
        add_vec(0, 1, 24'h000004, 24'h100004, 1, 0,  1, 4'b0111, 0,  4,  0,  0, 24'h000001, 24'h100001);
        add_vec(0, 0, 24'h0,      24'h0,      0, 1,  0, 4'b0000, 3,  1,  0,  2, 24'h0,      24'h0);
        add_vec(1, 0, 24'h0,      24'h0,      0, 0,  0, 4'b0000, 0,  0,  0,  0, 24'h0,      24'h0);
        for (int i = 1; i <= 6; i++) begin
            add_vec(0, 1, 24'h000010 + 24'(i), 24'h200010 + 24'(i), 0, 0,
                    0, 4'b0000, 0, 8'(i), 0, 0, 24'h0, 24'h0);
        end
        add_vec(0, 0, 24'h0,      24'h0,      1, 0,  1, 4'b1111, 0,  6,  0,  3, 24'h000014, 24'h200014);
        add_vec(0, 0, 24'h0,      24'h0,      0, 1,  0, 4'b0000, 4,  2,  0,  0, 24'h0,      24'h0);
        add_vec(0, 0, 24'h0,      24'h0,      1, 0,  1, 4'b0011, 4,  2,  0,  1, 24'h000016, 24'h200016);
        add_vec(0, 0, 24'h0,      24'h0,      0, 1,  0, 4'b0000, 6,  0,  0,  1, 24'h0,      24'h0);
        // load while empty, done while idle: both no-ops
        add_vec(0, 0, 24'h0,      24'h0,      1, 0,  0, 4'b0000, 6,  0,  0,  0, 24'h0,      24'h0);
        add_vec(0, 0, 24'h0,      24'h0,      0, 1,  0, 4'b0000, 6,  0,  0,  0, 24'h0,      24'h0);

        foreach (vecs[k]) begin
            apply(vecs[k].rst, vecs[k].sv, vecs[k].l, vecs[k].r, vecs[k].ld, vecs[k].dn);
            chk_state($sformatf("vec%0d", k), vecs[k].pv, vecs[k].pr, vecs[k].fc, vecs[k].fill);
            chk($sformatf("vec%0d overflow", k), 32'(overflow), 32'(vecs[k].ovf));
            chk_word($sformatf("vec%0d", k), vecs[k].widx, vecs[k].wl, vecs[k].wr);
            $display("vec %0d: pv=%0b present=%b fc=%0d fill=%0d", k, packet_valid,
                     audio_sample_word_present, frame_counter, fill_level);
        end

        // ---------------- overflow: 17 writes into DEPTH=16 ----------------
        apply(1, 0, 24'h0, 24'h0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, 24'h300000 + 24'(i), 24'h400000 + 24'(i), 0, 0);
            chk($sformatf("ovf write%0d overflow", i), 32'(overflow), 32'd0);
        end
        chk("ovf full fill_level", 32'(fill_level), 32'd16);
        apply(0, 1, 24'h300010, 24'h400010, 0, 0);
        chk("ovf drop overflow pulse", 32'(overflow), 32'd1);
        chk("ovf drop fill_level", 32'(fill_level), 32'd16);
`ifdef AUDIO_BUF_STATS_EN
        chk("ovf overflow_count", 32'(overflow_count), 32'd1);
`endif
        apply(0, 0, 24'h0, 24'h0, 0, 0);
        chk("ovf pulse ends", 32'(overflow), 32'd0);
        $display("overflow seq: fill=%0d after 17 writes", fill_level);
        for (int p = 0; p < 4; p++) begin
            apply(0, 0, 24'h0, 24'h0, 1, 0);
            chk_state($sformatf("drain%0d", p), 1'b1, 4'b1111, 8'(4 * p), 8'(16 - 4 * p));
            chk_word($sformatf("drain%0d", p), 0, 24'h300000 + 24'(4 * p), 24'h400000 + 24'(4 * p));
            chk_word($sformatf("drain%0d", p), 3, 24'h300003 + 24'(4 * p), 24'h400003 + 24'(4 * p));
            apply(0, 0, 24'h0, 24'h0, 0, 1);
            $display("drain packet %0d released: fc=%0d fill=%0d", p, frame_counter, fill_level);
        end
        chk_state("drained", 1'b0, 4'b0000, 8'd16, 8'd0);
        apply(0, 0, 24'h0, 24'h0, 1, 0);
        chk("empty load packet_valid", 32'(packet_valid), 32'd0);
`ifdef AUDIO_BUF_STATS_EN
        chk("empty load underrun", 32'(underrun), 32'd1);
`endif

        // ---------------- frame counter wrap ----------------
        apply(1, 0, 24'h0, 24'h0, 0, 0);
        for (int i = 0; i < 190; i++) begin
            apply(0, 1, 24'(i), 24'(i), 0, 0);
            apply(0, 0, 24'h0, 24'h0, 1, 0);
            apply(0, 0, 24'h0, 24'h0, 0, 1);
        end
        chk("wrap preload frame_counter", 32'(frame_counter), 32'd190);
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 24'h500000 + 24'(i), 24'h600000 + 24'(i), 0, 0);
        end
        apply(0, 0, 24'h0, 24'h0, 1, 0);
        chk_state("wrap held", 1'b1, 4'b1111, 8'd190, 8'd4);
        apply(0, 0, 24'h0, 24'h0, 0, 1);
        chk_state("wrap released", 1'b0, 4'b0000, 8'd2, 8'd0);
        $display("wrap seq: fc=%0d after 190+4 samples", frame_counter);

        // ---------------- load+done collision with push ----------------
        apply(1, 0, 24'h0, 24'h0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            apply(0, 1, 24'h700000 + 24'(i), 24'h800000 + 24'(i), 0, 0);
        end
        apply(0, 0, 24'h0, 24'h0, 1, 0);
        chk_state("coll held", 1'b1, 4'b1111, 8'd0, 8'd8);
        apply(0, 1, 24'h700008, 24'h800008, 1, 1);
        chk_state("coll release", 1'b0, 4'b0000, 8'd4, 8'd5);
        chk_word("coll release", 0, 24'h0, 24'h0);
        apply(0, 0, 24'h0, 24'h0, 0, 0);
        chk_state("coll idle", 1'b0, 4'b0000, 8'd4, 8'd5);
        apply(0, 0, 24'h0, 24'h0, 1, 0);
        chk_state("coll reload", 1'b1, 4'b1111, 8'd4, 8'd5);
        chk_word("coll reload", 0, 24'h700004, 24'h800004);
        $display("collision seq: fc=%0d fill=%0d", frame_counter, fill_level);

        // ---------------- reset during HOLD with 5 buffered ----------------
        apply(1, 0, 24'h0, 24'h0, 0, 0);
        chk_state("hold reset", 1'b0, 4'b0000, 8'd0, 8'd0);
        chk("hold reset overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk_word("hold reset", i, 24'h0, 24'h0);
        end
        apply(0, 0, 24'h0, 24'h0, 1, 0);
        chk("post-reset load ignored", 32'(packet_valid), 32'd0);
        $display("reset seq: pv=%0b fill=%0d fc=%0d", packet_valid, fill_level, frame_counter);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
